// File: rtl/aria_rk_seq.sv
// Round-key RAM address sequencer: multi-slot, ascending/descending passes over a valid/ready handshake.
// Optional ARIA_RK_RND_OUT_EN adds the rk_rnd_o beat counter and the rk_first_o flag.
module aria_rk_seq #(
   parameter int unsigned SLOT_W = 1,
   parameter int unsigned IDX_W  = 5,
   parameter int unsigned NR_128 = 12,
   parameter int unsigned NR_192 = 14,
   parameter int unsigned NR_256 = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic                    op_exp_i,
   input  logic                    flg_dec_i,
   input  logic [1:0]              st_ksize_i,
   input  logic [SLOT_W-1:0]       slot_i,
   input  logic                    abort_i,
   input  logic                    rk_rdy_i,
   output logic [SLOT_W+IDX_W-1:0] rk_addr_o,
   output logic                    rk_vld_o,
   output logic                    rk_we_o,
   output logic                    rk_last_o,
   output logic                    busy_o,
   output logic                    done_o,
`ifdef ARIA_RK_RND_OUT_EN
   output logic [IDX_W-1:0]        rk_rnd_o,
   output logic                    rk_first_o,
`endif
   output logic                    err_o
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d, nr_q, nr_d, nr_sel, end_idx;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic                exp_q, exp_d, dec_q, dec_d, err_q, err_d;
   logic                go, step, at_end;

   always_comb begin
      case (st_ksize_i)
         2'b01:   nr_sel = IDX_W'(NR_192);
         2'b10:   nr_sel = IDX_W'(NR_256);
         default: nr_sel = IDX_W'(NR_128);
      endcase
   end

   // abort beats both a new start and an in-flight handshake
   assign go      = (state_q == StIdle) && start_i && !abort_i && (st_ksize_i != 2'b11);
   assign step    = (state_q == StRun) && rk_rdy_i && !abort_i;
   assign end_idx = dec_q ? '0 : nr_q;
   assign at_end  = (idx_q == end_idx);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      nr_d    = nr_q;
      slot_d  = slot_q;
      exp_d   = exp_q;
      dec_d   = dec_q;
      err_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (go) begin
               state_d = StRun;
               slot_d  = slot_i;
               exp_d   = op_exp_i;
               dec_d   = !op_exp_i && flg_dec_i;
               nr_d    = nr_sel;
               idx_d   = (!op_exp_i && flg_dec_i) ? nr_sel : '0;
            end else if (start_i && !abort_i) begin
               err_d = 1'b1;
            end
         end
         StRun: begin
            if (abort_i) begin
               state_d = StIdle;
            end else if (step) begin
               // end check precedes the step, so idx never wraps
               if (at_end) state_d = StDone;
               else        idx_d   = dec_q ? idx_q - 1'b1 : idx_q + 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         idx_q   <= '0;
         nr_q    <= '0;
         slot_q  <= '0;
         exp_q   <= 1'b0;
         dec_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         nr_q    <= nr_d;
         slot_q  <= slot_d;
         exp_q   <= exp_d;
         dec_q   <= dec_d;
         err_q   <= err_d;
      end
   end

   assign rk_vld_o  = (state_q == StRun);
   assign rk_addr_o = {slot_q, idx_q};
   assign rk_we_o   = rk_vld_o && exp_q;
   assign rk_last_o = rk_vld_o && at_end;
   assign busy_o    = (state_q != StIdle);
   assign done_o    = (state_q == StDone);
   assign err_o     = err_q;

`ifdef ARIA_RK_RND_OUT_EN
   logic [IDX_W-1:0] rnd_q, rnd_d;

   always_comb begin
      rnd_d = rnd_q;
      if (go)                  rnd_d = '0;
      else if (step && !at_end) rnd_d = rnd_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rnd_q <= '0;
      else       rnd_q <= rnd_d;
   end

   assign rk_rnd_o   = rnd_q;
   assign rk_first_o = rk_vld_o && (rnd_q == '0);
`endif

endmodule

// File: tb/tb_aria_rk_seq.sv
// Directed self-checking bench for aria_rk_seq (default parameters, SLOT_W=1, IDX_W=5).
module tb_aria_rk_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, op_exp = 1'b0, flg_dec = 1'b0, abort = 1'b0, rk_rdy = 1'b0;
   logic [1:0] st_ksize = 2'b00;
   logic [0:0] slot = 1'b0;
   logic [5:0] rk_addr;
   logic       rk_vld, rk_we, rk_last, busy, done, err;
`ifdef ARIA_RK_RND_OUT_EN
   logic [4:0] rk_rnd;
   logic       rk_first;
`endif

   int passed = 0;
   int total  = 0;

   aria_rk_seq dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .op_exp_i   (op_exp),
      .flg_dec_i  (flg_dec),
      .st_ksize_i (st_ksize),
      .slot_i     (slot),
      .abort_i    (abort),
      .rk_rdy_i   (rk_rdy),
      .rk_addr_o  (rk_addr),
      .rk_vld_o   (rk_vld),
      .rk_we_o    (rk_we),
      .rk_last_o  (rk_last),
      .busy_o     (busy),
      .done_o     (done),
`ifdef ARIA_RK_RND_OUT_EN
      .rk_rnd_o   (rk_rnd),
      .rk_first_o (rk_first),
`endif
      .err_o      (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_pass(input logic op, input logic dec, input logic [1:0] ks,
                             input logic sl);
      op_exp = op; flg_dec = dec; st_ksize = ks; slot = sl; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic [10:0] act;
      tick();
      act = {rk_addr, rk_vld, rk_we, rk_last, busy, done};
      total++;
      if (act !== 11'd0 || err !== 1'b0)
         $display("FAIL reset: got %h err=%b want 0", act, err);
      else passed++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_expand();
      logic [8:0] act, exp_v;
      rk_rdy = 1'b1;
      start_pass(1'b1, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 13; i++) begin
         act   = {rk_vld, rk_addr, rk_we, rk_last};
         exp_v = {1'b1, 6'(i), 1'b1, 1'(i == 12)};
         total++;
         if (act !== exp_v) $display("FAIL t1_beat%0d: got %h want %h", i, act, exp_v);
         else passed++;
         tick();
      end
      total++;
      if ({done, rk_vld, busy} !== 3'b101)
         $display("FAIL t1_done: got %b want 101", {done, rk_vld, busy});
      else passed++;
      tick();
      total++;
      if ({done, busy} !== 2'b00) $display("FAIL t1_idle: got %b want 00", {done, busy});
      else passed++;
   endtask

   task automatic test_decrypt();
      logic [8:0] act, exp_v;
      rk_rdy = 1'b1;
      start_pass(1'b0, 1'b1, 2'b10, 1'b1);
      for (int i = 0; i < 17; i++) begin
         act   = {rk_vld, rk_addr, rk_we, rk_last};
         exp_v = {1'b1, 6'(8'h30 - i), 1'b0, 1'(i == 16)};
         total++;
         if (act !== exp_v) $display("FAIL t2_beat%0d: got %h want %h", i, act, exp_v);
         else passed++;
         tick();
      end
      total++;
      if ({done, rk_vld} !== 2'b10) $display("FAIL t2_done: got %b want 10", {done, rk_vld});
      else passed++;
      tick();
   endtask

   task automatic test_backpressure();
      logic [7:0] act, exp_v;
      int beats = 0;
      start_pass(1'b0, 1'b0, 2'b01, 1'b0);
      for (int c = 0; c < 100 && beats < 15; c++) begin
         rk_rdy = (c % 2 == 0);
         act    = {rk_vld, rk_addr, rk_last};
         exp_v  = {1'b1, 6'(beats), 1'(beats == 14)};
         total++;
         if (act !== exp_v) $display("FAIL t3_cyc%0d: got %h want %h", c, act, exp_v);
         else passed++;
         if (rk_rdy) beats++;
         tick();
      end
      rk_rdy = 1'b1;
      total++;
      if ({done, rk_vld} !== 2'b10) $display("FAIL t3_done: got %b want 10", {done, rk_vld});
      else passed++;
      tick();
   endtask

   task automatic test_illegal();
      rk_rdy = 1'b1;
      op_exp = 1'b0; flg_dec = 1'b0; st_ksize = 2'b11; start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if ({err, busy, rk_vld} !== 3'b100)
         $display("FAIL t4_err: got %b want 100", {err, busy, rk_vld});
      else passed++;
      tick();
      total++;
      if ({err, busy, rk_vld} !== 3'b000)
         $display("FAIL t4_errclr: got %b want 000", {err, busy, rk_vld});
      else passed++;
      start_pass(1'b1, 1'b0, 2'b00, 1'b0);
      total++;
      if ({rk_vld, rk_addr} !== 7'h40) $display("FAIL t4_legal: got %h want 40", {rk_vld, rk_addr});
      else passed++;
      repeat (13) tick();
      total++;
      if (done !== 1'b1) $display("FAIL t4_done: got %b want 1", done);
      else passed++;
      tick();
   endtask

   task automatic test_abort();
      rk_rdy = 1'b1;
      start_pass(1'b0, 1'b0, 2'b00, 1'b0);
      tick();
      st_ksize = 2'b11; start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if ({err, rk_addr, rk_vld, busy} !== {1'b0, 6'd2, 1'b1, 1'b1})
         $display("FAIL t5_busy_start: got %h want 0b", {err, rk_addr, rk_vld, busy});
      else passed++;
      tick();
      tick();
      tick();
      total++;
      if (rk_addr !== 6'd5) $display("FAIL t5_beat5: got %h want 05", rk_addr);
      else passed++;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++;
      if ({busy, rk_vld, done} !== 3'b000)
         $display("FAIL t5_abort: got %b want 000", {busy, rk_vld, done});
      else passed++;
      tick();
      total++;
      if ({busy, done} !== 2'b00) $display("FAIL t5_nodone: got %b want 00", {busy, done});
      else passed++;
   endtask

   task automatic test_async_reset();
      logic [11:0] act;
      rk_rdy = 1'b1;
      start_pass(1'b1, 1'b0, 2'b00, 1'b1);
      tick();
      total++;
      if (rk_addr !== 6'h21) $display("FAIL t6_pre: got %h want 21", rk_addr);
      else passed++;
      #2 rst = 1'b1;
      #1;
      act = {rk_addr, rk_vld, rk_we, rk_last, busy, done, err};
      total++;
      if (act !== 12'd0) $display("FAIL t6_rst: got %h want 000", act);
      else passed++;
`ifdef ARIA_RK_RND_OUT_EN
      total++;
      if (rk_rnd !== 5'd0) $display("FAIL t6_rnd: got %h want 00", rk_rnd);
      else passed++;
`endif
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_expand();
      test_decrypt();
      test_backpressure();
      test_illegal();
      test_abort();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
